mips_pipe_ctrl: RTL and testbench
=================================

// Module: mips_pipe_ctrl
// PURPOSE
//  Parametrised ID-stage control for the pipelined MIPS core: decodes opcode, registers control bundle into
//  ID/EX, detects load-use hazards with a configurable multi-cycle stall, flushes on taken branch/jump,
//  flags illegal opcodes with a saturating error counter. Sits between IF/ID register and EX stage.
// PARAMETERS
//  OPW           6   opcode field width
//  REGW          5   register specifier width
//  ALUOPW        2   ALU-op field width to ALU control
//  EXT_ISA       1   1: also decode ADDI (001000) and J (000010); 0: R/LW/SW/BEQ only
//  STALL_CYCLES  1   bubble cycles inserted per load-use hazard (1..15)
//  ERRW          8   illegal-opcode counter width
// PORTS
//  clk           in   1       core clock, all state on rising edge
//  rst_n         in   1       synchronous reset, active low
//  valid_id      in   1       IF/ID holds a real instruction
//  opcode_id     in   OPW     opcode of instruction in ID
//  rs_id, rt_id  in   REGW    source specifiers of instruction in ID
//  flush_ex      in   1       taken branch/jump resolved in EX this cycle
//  pc_write      out  1       PC load enable
//  ifid_write    out  1       IF/ID load enable
//  memread_ex, memwrite_ex, memtoreg_ex, regwrite_ex, regdst_ex, alusrc_ex, branch_ex, jump_ex  out 1 each
//  aluop_ex      out  ALUOPW  registered ALU-op
//  rt_ex         out  REGW    registered rt (used internally for hazard compare)
//  illegal_ex    out  1       registered illegal-opcode flag
//  err_count     out  ERRW    saturating count of illegal opcodes issued
// BEHAVIOUR
//  Reset (rst_n=0 at edge): all *_ex, rt_ex, illegal_ex, err_count <= 0; FSM <= RUN; stall counter <= 0.
//   pc_write=ifid_write=0 combinationally while rst_n=0.
//  Decode table (comb): R 000000: regwrite,regdst,aluop=10. LW 100011: memread,memtoreg,regwrite,alusrc,
//   aluop=00. SW 101011: memwrite,alusrc. BEQ 000100: branch,aluop=01. ADDI 001000 (EXT_ISA): regwrite,
//   alusrc,aluop=00. J 000010 (EXT_ISA): jump. Any other opcode, or ADDI/J with EXT_ISA=0: all 0, illegal=1.
//   valid_id=0: all 0, illegal=0.
//  Latency: decoded bundle appears on *_ex exactly 1 cycle after opcode_id sampled.
//  Hazard (comb): valid_id & memread_ex & rt_ex!=0 & (rt_ex==rs_id | (rt_ex==rt_id & op in {R,SW,BEQ})).
//  FSM RUN: no hazard -> load decoded bundle, pc_write=ifid_write=1.
//   hazard -> load bubble (all *_ex=0, rt_ex=0), pc_write=ifid_write=0, cnt<=STALL_CYCLES-1,
//   go STALL if STALL_CYCLES>1 else stay RUN (bubble clears memread_ex so hazard drops next cycle).
//  FSM STALL: load bubble, pc_write=ifid_write=0, cnt--; at cnt==0 -> RUN (re-decode ID instruction).
//  flush_ex=1 (any state): ID/EX <= bubble, FSM <= RUN, cnt <= 0, pc_write=1, ifid_write=1
//   (IF/ID squashing is owner's job). Flush overrides hazard and stall in the same cycle.
//  err_count: +1 when illegal decode is actually loaded into ID/EX (not on bubble/flush); holds at 2^ERRW-1.
//  Reset mid-stall: next cycle RUN, all outputs 0; no residual stall.
// STRUCTURE
//  mips_ctrl_pkg: opcode constants, ALUOP encodings (ADD=00,SUB=01,FUNCT=10), FSM state enum, ctrl bundle
//   struct {memread,memwrite,memtoreg,regwrite,regdst,alusrc,branch,jump,aluop,illegal}.
//  Sub-module mips_main_decoder: pure combinational decode table (opcode,valid,EXT_ISA -> bundle).
//  Top holds ID/EX bundle register, hazard compare, stall FSM+counter, error counter.
// TESTING
//  1 Reset: rst_n=0 two cycles, opcode LW valid -> all *_ex=0, err_count=0, pc_write=0; release -> LW bundle next cycle.
//  2 Decode sweep: R,LW,SW,BEQ,ADDI,J back-to-back, EXT_ISA=1 -> each bundle per table 1 cycle later, no stalls.
//  3 Load-use: LW rt=5 then ADD rs=5, STALL_CYCLES=3 -> pc_write/ifid_write low 3 cycles, 3 bubbles, then ADD issued.
//  4 No false hazard: LW rt=0 then ADD rs=0; LW rt=5 then ADDI rt=5 (dest only) -> no stall.
//  5 Flush mid-stall: flush_ex=1 in 2nd stall cycle -> bubble, FSM RUN, pc_write=1 same cycle.
//  6 Illegal: opcode 111111 x300 valid, EXT_ISA=0 also J -> illegal_ex=1 each, err_count saturates at 255.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the MIPS ID-stage control block:
// opcodes, ALU-op encodings, stall FSM states and the ID/EX control bundle.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       regdst;
    logic       alusrc;
    logic       branch;
    logic       jump;
    logic [1:0] aluop;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mips_main_decoder.sv
// Pure combinational main decoder: opcode + valid -> control bundle.
// ADDI and J are only recognised when EXT_ISA is set; otherwise they decode as illegal.
module mips_main_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int OPW     = 6,
  parameter bit EXT_ISA = 1'b1
) (
  input  logic           valid_i,
  input  logic [OPW-1:0] opcode_i,
  output ctrl_t          ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    if (valid_i) begin
      case (opcode_i)
        OPW'(OP_R): begin
          ctrl_o.regwrite = 1'b1;
          ctrl_o.regdst   = 1'b1;
          ctrl_o.aluop    = ALUOP_FUNCT;
        end
        OPW'(OP_LW): begin
          ctrl_o.memread  = 1'b1;
          ctrl_o.memtoreg = 1'b1;
          ctrl_o.regwrite = 1'b1;
          ctrl_o.alusrc   = 1'b1;
          ctrl_o.aluop    = ALUOP_ADD;
        end
        OPW'(OP_SW): begin
          ctrl_o.memwrite = 1'b1;
          ctrl_o.alusrc   = 1'b1;
        end
        OPW'(OP_BEQ): begin
          ctrl_o.branch = 1'b1;
          ctrl_o.aluop  = ALUOP_SUB;
        end
        OPW'(OP_ADDI): begin
          if (EXT_ISA) begin
            ctrl_o.regwrite = 1'b1;
            ctrl_o.alusrc   = 1'b1;
            ctrl_o.aluop    = ALUOP_ADD;
          end else begin
            ctrl_o.illegal = 1'b1;
          end
        end
        OPW'(OP_J): begin
          if (EXT_ISA) ctrl_o.jump = 1'b1;
          else         ctrl_o.illegal = 1'b1;
        end
        default: ctrl_o.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mips_pipe_ctrl.sv
// ID-stage control: registers the decoded bundle into ID/EX, stalls on load-use
// hazards for STALL_CYCLES bubbles, flushes on taken branch/jump, counts illegal opcodes.
module mips_pipe_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OPW          = 6,
  parameter int REGW         = 5,
  parameter int ALUOPW       = 2,
  parameter bit EXT_ISA      = 1'b1,
  parameter int STALL_CYCLES = 1,
  parameter int ERRW         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_id,
  input  logic [OPW-1:0]    opcode_id,
  input  logic [REGW-1:0]   rs_id,
  input  logic [REGW-1:0]   rt_id,
  input  logic              flush_ex,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              memread_ex,
  output logic              memwrite_ex,
  output logic              memtoreg_ex,
  output logic              regwrite_ex,
  output logic              regdst_ex,
  output logic              alusrc_ex,
  output logic              branch_ex,
  output logic              jump_ex,
  output logic [ALUOPW-1:0] aluop_ex,
  output logic [REGW-1:0]   rt_ex,
  output logic              illegal_ex,
  output logic [ERRW-1:0]   err_count
);

  ctrl_t            dec;
  ctrl_t            ex_q, ex_d;
  logic [REGW-1:0]  rt_q, rt_d;
  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [ERRW-1:0]  err_q, err_d;
  logic             load_dec;
  logic             uses_rt;
  logic             hazard;

  mips_main_decoder #(
    .OPW     (OPW),
    .EXT_ISA (EXT_ISA)
  ) u_dec (
    .valid_i  (valid_id),
    .opcode_i (opcode_id),
    .ctrl_o   (dec)
  );

  // rt is only a true source for R-type, SW and BEQ; for LW/ADDI it is the destination.
  assign uses_rt = (opcode_id == OPW'(OP_R)) || (opcode_id == OPW'(OP_SW)) ||
                   (opcode_id == OPW'(OP_BEQ));
  assign hazard  = valid_id && ex_q.memread && (rt_q != '0) &&
                   ((rt_q == rs_id) || ((rt_q == rt_id) && uses_rt));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_dec   = 1'b0;
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    if (flush_ex) begin
      state_d    = ST_RUN;
      cnt_d      = '0;
      pc_write   = 1'b1;
      ifid_write = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hazard) begin
            cnt_d   = 4'(STALL_CYCLES - 1);
            state_d = (STALL_CYCLES > 1) ? ST_STALL : ST_RUN;
          end else begin
            load_dec   = 1'b1;
            pc_write   = 1'b1;
            ifid_write = 1'b1;
          end
        end
        ST_STALL: begin
          // Leave once the counter reaches zero so exactly STALL_CYCLES bubbles are issued.
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
    if (!rst_n) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end
  end

  always_comb begin
    ex_d  = load_dec ? dec : '0;
    rt_d  = load_dec ? rt_id : '0;
    err_d = err_q;
    if (load_dec && dec.illegal && (err_q != '1)) err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      ex_q    <= '0;
      rt_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
      rt_q    <= rt_d;
      err_q   <= err_d;
    end
  end

  assign memread_ex  = ex_q.memread;
  assign memwrite_ex = ex_q.memwrite;
  assign memtoreg_ex = ex_q.memtoreg;
  assign regwrite_ex = ex_q.regwrite;
  assign regdst_ex   = ex_q.regdst;
  assign alusrc_ex   = ex_q.alusrc;
  assign branch_ex   = ex_q.branch;
  assign jump_ex     = ex_q.jump;
  assign aluop_ex    = ALUOPW'(ex_q.aluop);
  assign illegal_ex  = ex_q.illegal;
  assign rt_ex       = rt_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// Directed bench for mips_pipe_ctrl: dut_a (EXT_ISA=1, 3-cycle stall) and
// dut_b (EXT_ISA=0, 1-cycle stall) share one stimulus stream.
module tb_mips_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_id;
  logic [5:0] opcode_id;
  logic [4:0] rs_id, rt_id;
  logic       flush_ex;

  logic       pc_write_a, ifid_write_a, pc_write_b, ifid_write_b;
  logic       mr_a, mw_a, mtr_a, rw_a, rd_a, as_a, br_a, j_a, ill_a;
  logic       mr_b, mw_b, mtr_b, rw_b, rd_b, as_b, br_b, j_b, ill_b;
  logic [1:0] aluop_a, aluop_b;
  logic [4:0] rt_ex_a, rt_ex_b;
  logic [7:0] err_a, err_b;

  int checks = 0;
  int errors = 0;

  localparam logic [10:0] B_R    = 11'b00011000100;
  localparam logic [10:0] B_LW   = 11'b10110100000;
  localparam logic [10:0] B_SW   = 11'b01000100000;
  localparam logic [10:0] B_BEQ  = 11'b00000010010;
  localparam logic [10:0] B_ADDI = 11'b00010100000;
  localparam logic [10:0] B_J    = 11'b00000001000;
  localparam logic [10:0] B_ILL  = 11'b00000000001;
  localparam logic [10:0] B_NONE = 11'b00000000000;

  always #5 clk = ~clk;

  mips_pipe_ctrl #(.EXT_ISA(1'b1), .STALL_CYCLES(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .valid_id(valid_id), .opcode_id(opcode_id),
    .rs_id(rs_id), .rt_id(rt_id), .flush_ex(flush_ex),
    .pc_write(pc_write_a), .ifid_write(ifid_write_a),
    .memread_ex(mr_a), .memwrite_ex(mw_a), .memtoreg_ex(mtr_a), .regwrite_ex(rw_a),
    .regdst_ex(rd_a), .alusrc_ex(as_a), .branch_ex(br_a), .jump_ex(j_a),
    .aluop_ex(aluop_a), .rt_ex(rt_ex_a), .illegal_ex(ill_a), .err_count(err_a)
  );

  mips_pipe_ctrl #(.EXT_ISA(1'b0), .STALL_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .valid_id(valid_id), .opcode_id(opcode_id),
    .rs_id(rs_id), .rt_id(rt_id), .flush_ex(flush_ex),
    .pc_write(pc_write_b), .ifid_write(ifid_write_b),
    .memread_ex(mr_b), .memwrite_ex(mw_b), .memtoreg_ex(mtr_b), .regwrite_ex(rw_b),
    .regdst_ex(rd_b), .alusrc_ex(as_b), .branch_ex(br_b), .jump_ex(j_b),
    .aluop_ex(aluop_b), .rt_ex(rt_ex_b), .illegal_ex(ill_b), .err_count(err_b)
  );

  function automatic logic [10:0] obs_a();
    return {mr_a, mw_a, mtr_a, rw_a, rd_a, as_a, br_a, j_a, aluop_a, ill_a};
  endfunction

  function automatic logic [10:0] obs_b();
    return {mr_b, mw_b, mtr_b, rw_b, rd_b, as_b, br_b, j_b, aluop_b, ill_b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    valid_id  = v;
    opcode_id = op;
    rs_id     = rs;
    rt_id     = rt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush_ex = 1'b0;
    drive(1'b1, 6'b100011, 5'd0, 5'd0);
    tick();
    tick();
    checks++;
    if (obs_a() !== B_NONE || rt_ex_a !== 5'd0) begin
      errors++; $display("FAIL reset_bundle: got %b rt %0d, want %b rt 0", obs_a(), rt_ex_a, B_NONE);
    end
    checks++;
    if (err_a !== 8'd0) begin errors++; $display("FAIL reset_err: got %0d, want 0", err_a); end
    checks++;
    if (pc_write_a !== 1'b0 || ifid_write_a !== 1'b0) begin
      errors++; $display("FAIL reset_pcwrite: got %b%b, want 00", pc_write_a, ifid_write_a);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (pc_write_a !== 1'b1) begin errors++; $display("FAIL release_pcwrite: got %b, want 1", pc_write_a); end
    tick();
    checks++;
    if (obs_a() !== B_LW) begin errors++; $display("FAIL release_lw: got %b, want %b", obs_a(), B_LW); end
    drive(1'b0, 6'b000000, 5'd0, 5'd0);
    tick();
    checks++;
    if (obs_a() !== B_NONE) begin errors++; $display("FAIL invalid_bubble: got %b, want %b", obs_a(), B_NONE); end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 6'b100011, 5'd0, 5'd5);
    tick();
    drive(1'b1, 6'b000000, 5'd5, 5'd1);
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (pc_write_a !== 1'b0) begin errors++; $display("FAIL rst_stall_pcwrite: got %b, want 0", pc_write_a); end
    tick();
    checks++;
    if (obs_a() !== B_NONE) begin errors++; $display("FAIL rst_stall_bundle: got %b, want 0", obs_a()); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (pc_write_a !== 1'b1) begin errors++; $display("FAIL rst_stall_norun: got %b, want 1", pc_write_a); end
    tick();
    checks++;
    if (obs_a() !== B_R) begin errors++; $display("FAIL rst_stall_issue: got %b, want %b", obs_a(), B_R); end
    drive(1'b0, 6'b000000, 5'd0, 5'd0);
    tick();
  endtask

  task automatic test_decode_sweep();
    logic [5:0]  ops [6]   = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    logic [10:0] exp_a [6] = '{B_R, B_LW, B_SW, B_BEQ, B_ADDI, B_J};
    logic [10:0] exp_b [6] = '{B_R, B_LW, B_SW, B_BEQ, B_ILL, B_ILL};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, ops[i], 5'd1, (ops[i] == 6'b100011) ? 5'd3 : 5'd2);
      #1;
      checks++;
      if (pc_write_a !== 1'b1 || ifid_write_a !== 1'b1) begin
        errors++; $display("FAIL sweep_nostall[%0d]: got %b%b, want 11", i, pc_write_a, ifid_write_a);
      end
      tick();
      checks++;
      if (obs_a() !== exp_a[i]) begin errors++; $display("FAIL sweep_a[%0d]: got %b, want %b", i, obs_a(), exp_a[i]); end
      checks++;
      if (obs_b() !== exp_b[i]) begin errors++; $display("FAIL sweep_b[%0d]: got %b, want %b", i, obs_b(), exp_b[i]); end
    end
    checks++;
    if (err_b !== 8'd2) begin errors++; $display("FAIL sweep_err_b: got %0d, want 2", err_b); end
    checks++;
    if (err_a !== 8'd0) begin errors++; $display("FAIL sweep_err_a: got %0d, want 0", err_a); end
    drive(1'b0, 6'b000000, 5'd0, 5'd0);
    tick();
  endtask

  task automatic test_load_use();
    drive(1'b1, 6'b100011, 5'd0, 5'd5);
    tick();
    checks++;
    if (obs_a() !== B_LW || rt_ex_a !== 5'd5) begin
      errors++; $display("FAIL lu_lw: got %b rt %0d, want %b rt 5", obs_a(), rt_ex_a, B_LW);
    end
    drive(1'b1, 6'b000000, 5'd5, 5'd1);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (pc_write_a !== 1'b0 || ifid_write_a !== 1'b0) begin
        errors++; $display("FAIL lu_stall[%0d]: got %b%b, want 00", c, pc_write_a, ifid_write_a);
      end
      tick();
      checks++;
      if (obs_a() !== B_NONE || rt_ex_a !== 5'd0) begin
        errors++; $display("FAIL lu_bubble[%0d]: got %b rt %0d, want 0", c, obs_a(), rt_ex_a);
      end
      if (c == 1) begin
        checks++;
        if (obs_b() !== B_R) begin errors++; $display("FAIL lu_b_issue: got %b, want %b", obs_b(), B_R); end
      end
    end
    #1;
    checks++;
    if (pc_write_a !== 1'b1) begin errors++; $display("FAIL lu_resume: got %b, want 1", pc_write_a); end
    tick();
    checks++;
    if (obs_a() !== B_R) begin errors++; $display("FAIL lu_issue: got %b, want %b", obs_a(), B_R); end
    drive(1'b0, 6'b000000, 5'd0, 5'd0);
    tick();
  endtask

  task automatic test_no_false_hazard();
    drive(1'b1, 6'b100011, 5'd0, 5'd0);
    tick();
    drive(1'b1, 6'b000000, 5'd0, 5'd0);
    #1;
    checks++;
    if (pc_write_a !== 1'b1) begin errors++; $display("FAIL nfh_r0: got %b, want 1", pc_write_a); end
    tick();
    checks++;
    if (obs_a() !== B_R) begin errors++; $display("FAIL nfh_r0_issue: got %b, want %b", obs_a(), B_R); end
    drive(1'b1, 6'b100011, 5'd0, 5'd5);
    tick();
    drive(1'b1, 6'b001000, 5'd1, 5'd5);
    #1;
    checks++;
    if (pc_write_a !== 1'b1) begin errors++; $display("FAIL nfh_addi: got %b, want 1", pc_write_a); end
    tick();
    checks++;
    if (obs_a() !== B_ADDI) begin errors++; $display("FAIL nfh_addi_issue: got %b, want %b", obs_a(), B_ADDI); end
    drive(1'b0, 6'b000000, 5'd0, 5'd0);
    tick();
  endtask

  task automatic test_flush_mid_stall();
    drive(1'b1, 6'b100011, 5'd0, 5'd5);
    tick();
    drive(1'b1, 6'b000000, 5'd5, 5'd1);
    tick();
    flush_ex = 1'b1;
    #1;
    checks++;
    if (pc_write_a !== 1'b1 || ifid_write_a !== 1'b1) begin
      errors++; $display("FAIL flush_pcwrite: got %b%b, want 11", pc_write_a, ifid_write_a);
    end
    tick();
    checks++;
    if (obs_a() !== B_NONE) begin errors++; $display("FAIL flush_bubble: got %b, want 0", obs_a()); end
    flush_ex = 1'b0;
    #1;
    checks++;
    if (pc_write_a !== 1'b1) begin errors++; $display("FAIL flush_run: got %b, want 1", pc_write_a); end
    tick();
    checks++;
    if (obs_a() !== B_R) begin errors++; $display("FAIL flush_issue: got %b, want %b", obs_a(), B_R); end
    drive(1'b0, 6'b000000, 5'd0, 5'd0);
    tick();
  endtask

  task automatic test_illegal();
    for (int i = 1; i <= 300; i++) begin
      drive(1'b1, 6'b111111, 5'd0, 5'd0);
      tick();
      checks++;
      if (ill_a !== 1'b1 || ill_b !== 1'b1) begin
        errors++; $display("FAIL ill_flag[%0d]: got %b%b, want 11", i, ill_a, ill_b);
      end
      if (i == 254 || i == 255) begin
        checks++;
        if (err_a !== 8'(i)) begin errors++; $display("FAIL ill_count[%0d]: got %0d, want %0d", i, err_a, i); end
      end
    end
    checks++;
    if (err_a !== 8'd255 || err_b !== 8'd255) begin
      errors++; $display("FAIL ill_sat: got %0d/%0d, want 255/255", err_a, err_b);
    end
    drive(1'b1, 6'b000010, 5'd0, 5'd0);
    tick();
    checks++;
    if (obs_b() !== B_ILL || err_b !== 8'd255) begin
      errors++; $display("FAIL ill_j_b: got %b cnt %0d, want %b cnt 255", obs_b(), err_b, B_ILL);
    end
    checks++;
    if (obs_a() !== B_J) begin errors++; $display("FAIL ill_j_a: got %b, want %b", obs_a(), B_J); end
    drive(1'b0, 6'b000000, 5'd0, 5'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_reset_mid_stall();
    test_decode_sweep();
    test_load_use();
    test_no_false_hazard();
    test_flush_mid_stall();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
